// File: rtl/region_bus_ctrl.sv
// rtl/region_bus_ctrl.sv - CPU request decoder/sequencer over N wait-stated regions plus read-only ctrl words.
// Optional BUS_ERR_REPORT_EN: error responses and a saturating err_count output.
module region_bus_ctrl #(
   parameter int                      N_REGIONS   = 4,
   parameter logic [N_REGIONS*32-1:0] REGION_BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
   parameter logic [N_REGIONS*32-1:0] REGION_MASK = {4{32'hFFFF_F000}},
   parameter logic [N_REGIONS*4-1:0]  WAIT_STATES = {4'd0, 4'd2, 4'd1, 4'd1},
   parameter int                      N_CTRL      = 2,
   parameter logic [31:0]             CTRL_BASE   = 32'h0000_F000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   input  logic                      req_we,
   input  logic [31:0]               req_addr,
   input  logic [31:0]               req_wd,
   output logic                      req_ready,
   output logic                      resp_valid,
   output logic [31:0]               resp_rd,
   output logic                      resp_err,
   input  logic [N_CTRL*32-1:0]      ctrl_val,
   output logic [N_REGIONS-1:0]      reg_we,
   output logic [N_REGIONS*32-1:0]   reg_addr,
   output logic [31:0]               reg_wd,
   input  logic [N_REGIONS*32-1:0]   reg_rd
`ifdef BUS_ERR_REPORT_EN
   ,
   output logic [15:0]               err_count
`endif
);

   localparam int SW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
   localparam int CW = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_we;
   logic [31:0]     r_addr;
   logic [31:0]     r_wd;
   logic            r_is_ctrl;
   logic [SW-1:0]   r_sel;
   logic [CW-1:0]   r_cidx;
   logic [3:0]      r_cnt;
   logic            r_first;
   logic [31:0]     r_rdata;
`ifdef BUS_ERR_REPORT_EN
   logic            r_err;
`endif

   logic            w_accept;
   logic [31:0]     w_ctrl_off;
   logic            w_ctrl_hit;
   logic [CW-1:0]   w_ctrl_idx;
   logic            w_reg_hit;
   logic [SW-1:0]   w_reg_sel;
   logic [3:0]      w_wait;
   logic [31:0]     w_reg_data;
   logic [31:0]     w_ctrl_data;

   // Address decode; ctrl window overrides regions, lowest region index wins.
   always_comb begin
      w_ctrl_off = req_addr - CTRL_BASE;
      w_ctrl_hit = (req_addr >= CTRL_BASE) && (w_ctrl_off < 32'(4 * N_CTRL));
      w_ctrl_idx = w_ctrl_off[CW+1:2];
      w_reg_hit  = 1'b0;
      w_reg_sel  = '0;
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
         if ((req_addr & REGION_MASK[32*i +: 32]) == REGION_BASE[32*i +: 32]) begin
            w_reg_hit = 1'b1;
            w_reg_sel = i[SW-1:0];
         end
      end
      w_wait = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         if (w_reg_sel == i[SW-1:0]) w_wait = WAIT_STATES[4*i +: 4];
      end
   end

   always_comb begin
      w_reg_data  = '0;
      w_ctrl_data = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         if (r_sel == i[SW-1:0]) w_reg_data = reg_rd[32*i +: 32];
      end
      for (int i = 0; i < N_CTRL; i++) begin
         if (r_cidx == i[CW-1:0]) w_ctrl_data = ctrl_val[32*i +: 32];
      end
   end

   assign w_accept = req_valid && (r_state == S_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wd      <= '0;
         r_is_ctrl <= 1'b0;
         r_sel     <= '0;
         r_cidx    <= '0;
         r_cnt     <= '0;
         r_first   <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we      <= req_we;
            r_addr    <= req_addr;
            r_wd      <= req_wd;
            r_is_ctrl <= w_ctrl_hit;
            r_sel     <= w_reg_sel;
            r_cidx    <= w_ctrl_idx;
            r_cnt     <= w_ctrl_hit ? 4'd0 : w_wait;
            r_first   <= 1'b1;
            r_rdata   <= '0;
         end else if (r_state == S_ACCESS) begin
            r_first <= 1'b0;
            if (r_cnt != 4'd0) begin
               r_cnt <= r_cnt - 4'd1;
            end else if (!r_we) begin
               r_rdata <= r_is_ctrl ? w_ctrl_data : w_reg_data;
            end
         end
      end
   end

`ifdef BUS_ERR_REPORT_EN
   // Error = unmapped target or a write into the read-only ctrl window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err     <= 1'b0;
         err_count <= '0;
      end else begin
         if (w_accept) r_err <= !(w_ctrl_hit || w_reg_hit) || (w_ctrl_hit && req_we);
         if ((r_state == S_RESP) && r_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      end
   end
`endif

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rd    = '0;
      resp_err   = 1'b0;
      reg_we     = '0;
      reg_addr   = '0;
      reg_wd     = r_wd;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = (w_ctrl_hit || w_reg_hit) ? S_ACCESS : S_RESP;
         end
         S_ACCESS: begin
            if (r_cnt == 4'd0) w_next = S_RESP;
            for (int i = 0; i < N_REGIONS; i++) begin
               if (!r_is_ctrl && (r_sel == i[SW-1:0])) begin
                  reg_addr[32*i +: 32] = r_addr - REGION_BASE[32*i +: 32];
                  reg_we[i]            = r_first && r_we;
               end
            end
         end
         S_RESP: begin
            w_next     = S_IDLE;
            resp_valid = 1'b1;
            resp_rd    = r_rdata;
`ifdef BUS_ERR_REPORT_EN
            resp_err   = r_err;
`endif
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_region_bus_ctrl.sv
// tb/tb_region_bus_ctrl.sv - randomized self-checking bench for region_bus_ctrl against an address-map model.
module tb_region_bus_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid, req_we;
   logic [31:0]  req_addr, req_wd;
   logic         req_ready, resp_valid, resp_err;
   logic [31:0]  resp_rd;
   logic [63:0]  ctrl_val;
   logic [3:0]   reg_we;
   logic [127:0] reg_addr;
   logic [31:0]  reg_wd;
   logic [127:0] reg_rd;
`ifdef BUS_ERR_REPORT_EN
   logic [15:0]  err_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int err_exp = 0;
   int wtab[4] = '{1, 1, 2, 0};

   always #5 clk = ~clk;

   region_bus_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wd(req_wd),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_err(resp_err),
      .ctrl_val(ctrl_val), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wd(reg_wd), .reg_rd(reg_rd)
`ifdef BUS_ERR_REPORT_EN
      , .err_count(err_count)
`endif
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Address map: ctrl words at F000/F004, region k at k*4K for k<4, everything else unmapped.
   task automatic model(input logic [31:0] addr, input logic we, output int ri, output int lat,
                        output logic [31:0] rd, output logic err, output logic [31:0] off);
      ri = -1; off = 0; rd = 0; err = 0;
      if (addr >= 32'h0000_F000 && addr < 32'h0000_F008) begin
         lat = 2;
         if (!we) rd = ctrl_val[32*((addr - 32'h0000_F000) / 4) +: 32];
         err = we;
      end else if (addr < 32'h0000_4000) begin
         ri  = int'(addr / 4096);
         off = addr - 32'(ri * 4096);
         lat = 2 + wtab[ri];
         if (!we) rd = reg_rd[32*ri +: 32];
      end else begin
         lat = 1;
         err = 1'b1;
      end
`ifndef BUS_ERR_REPORT_EN
      err = 1'b0;
`endif
   endtask

   // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
   task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wd);
      int ri, lat;
      logic [31:0] rd, off;
      logic err;
      logic [3:0] e_we;
      logic [127:0] e_ra;
      model(addr, we, ri, lat, rd, err, off);
      check("ready_before", req_ready, 1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wd = wd;
      for (int n = 1; n <= lat + 1; n++) begin
         @(posedge clk); @(negedge clk);
         if (n == 1) begin
            req_addr = $urandom; req_we = 1'($urandom); req_wd = $urandom;
         end
         e_we = (n == 1 && ri >= 0 && we) ? 4'(1 << ri) : 4'd0;
         e_ra = (ri >= 0 && n <= lat - 1) ? (128'(off) << (32 * ri)) : 128'd0;
         check("reg_we", reg_we, e_we);
         check("reg_addr", reg_addr, e_ra);
         check("resp_valid", resp_valid, n == lat);
         check("resp_rd", resp_rd, (n == lat) ? rd : 32'd0);
         check("resp_err", resp_err, (n == lat) ? err : 1'b0);
         check("req_ready", req_ready, n > lat);
         if (n == 1 && we) check("reg_wd", reg_wd, wd);
      end
      req_valid = 1'b0;
      if (err && err_exp < 65535) err_exp++;
`ifdef BUS_ERR_REPORT_EN
      check("err_count", err_count, err_exp);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int ri;
      logic [31:0] a;
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wd = '0;
      ctrl_val = {32'h0000_00A5, 32'h1234_5678};
      reg_rd = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_1111};
      repeat (2) @(negedge clk);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rd", resp_rd, 0);
      check("rst_reg_we", reg_we, 0);
      check("rst_reg_addr", reg_addr, 0);
      check("rst_reg_wd", reg_wd, 0);
`ifdef BUS_ERR_REPORT_EN
      check("rst_err_count", err_count, 0);
`endif
      reset = 1'b1;
      @(negedge clk);

      run_txn(32'h0000_1004, 1'b0, 32'h0);
      run_txn(32'h0000_2010, 1'b1, 32'h0000_0055);
      run_txn(32'h0000_F004, 1'b0, 32'h0);
      run_txn(32'h0001_0000, 1'b0, 32'h0);
      run_txn(32'h0000_F000, 1'b1, 32'hCAFE_0001);
      run_txn(32'h0000_3FFC, 1'b0, 32'h0);

      for (int k = 0; k < 40; k++) begin
         reg_rd   = {$urandom, $urandom, $urandom, $urandom};
         ctrl_val = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0, 1: a = 32'($urandom_range(0, 3) * 4096 + $urandom_range(0, 1023) * 4);
            2:    a = 32'h0000_F000 + 32'($urandom_range(0, 1) * 4);
            default: a = 32'h0001_0000 + 32'($urandom_range(0, 65535) * 4);
         endcase
         run_txn(a, 1'($urandom), $urandom);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      // Back-to-back region-0 reads with req_valid held: accepts every W0+3 cycles.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
      for (int c = 0; c <= 12; c++) begin
         check("b2b_ready", req_ready, (c % (wtab[0] + 3)) == 0);
         if (c == 9) req_valid = 1'b0;
         @(posedge clk); @(negedge clk);
      end

      // Reset in the middle of a region-2 write.
      run_txn(32'h0001_2340, 1'b0, 32'h0);
      check("pre_rst_ready", req_ready, 1);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_2010; req_wd = 32'h0000_0055;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_reg_we", reg_we, 0);
      check("midrst_reg_addr", reg_addr, 0);
      check("midrst_reg_wd", reg_wd, 0);
      check("midrst_resp_valid", resp_valid, 0);
      check("midrst_resp_rd", resp_rd, 0);
      check("midrst_resp_err", resp_err, 0);
`ifdef BUS_ERR_REPORT_EN
      check("midrst_err_count", err_count, 0);
`endif
      err_exp = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("post_rst_ready", req_ready, 1);
         check("post_rst_reg_we", reg_we, 0);
         check("post_rst_resp_valid", resp_valid, 0);
         @(negedge clk);
      end
      run_txn(32'h0000_1008, 1'b0, 32'h0);
      run_txn(32'h0000_5000, 1'b1, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
